// File: rtl/out_transmitter.sv
// -----------------------------------------------------------------------------
// out_transmitter
//
// Serialises one result matrix into a framed byte stream for the UART byte
// transmitter:
//    0xA5, dim_x, dim_y, dim_x*dim_y elements (BYTES bytes each, MSB first), chk
// where chk is the XOR of every frame byte except the 0xA5 sync byte.
//
// Parameters:
//    DATA_WIDTH     element width in bits (multiple of 8, 8..64)
//    BYTES          bytes per element, derived from DATA_WIDTH
//
// Ports:
//    clk            clock
//    rst_n          synchronous active-low reset
//    data_available one-cycle pulse: a matrix is loaded and waiting
//    dim_x, dim_y   matrix dimensions, captured when data_available is taken
//    tx_ready       one-cycle pulse once the header has been sent
//    stopped        backpressure to the element source (1 = nothing accepted)
//    elem_valid     element source presents elem_data
//    elem_data      element value
//    tx_valid       tx_byte is valid; held with a stable byte until acked
//    tx_byte        byte towards the UART
//    tx_ack         UART consumes the byte (only meaningful with tx_valid)
//    busy           transmitter is not idle
// -----------------------------------------------------------------------------
module out_transmitter #(
   parameter  int DATA_WIDTH = 32,
   localparam int BYTES      = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  data_available,
   input  logic [7:0]            dim_x,
   input  logic [7:0]            dim_y,
   output logic                  tx_ready,
   output logic                  stopped,
   input  logic                  elem_valid,
   input  logic [DATA_WIDTH-1:0] elem_data,
   output logic                  tx_valid,
   output logic [7:0]            tx_byte,
   input  logic                  tx_ack,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_GRANT,
      S_WAIT_ELEM,
      S_ELEM,
      S_CHK
   } state_t;

   localparam logic [7:0] SYNC_BYTE     = 8'hA5;
   localparam logic [2:0] LAST_BYTE_IDX = 3'(BYTES - 1);

   state_t                state_reg, state_next;
   logic [7:0]            dim_x_reg, dim_y_reg;
   logic [7:0]            chk_reg;
   logic [7:0]            tx_byte_reg;
   logic                  tx_valid_reg;
   logic [2:0]            byte_idx_reg;
   logic [15:0]           elem_cnt_reg;
   logic [DATA_WIDTH-1:0] shift_reg;

   logic                  byte_done;
   logic [15:0]           elem_total;
   logic                  last_elem_byte;
   logic                  last_elem;

   // A byte only leaves when it is both offered and acked.
   assign byte_done      = tx_valid_reg && tx_ack;
   assign elem_total     = 16'(dim_x_reg) * 16'(dim_y_reg);
   assign last_elem_byte = (byte_idx_reg == LAST_BYTE_IDX);
   assign last_elem      = ((elem_cnt_reg + 16'd1) == elem_total);

   // Handshake outputs are decoded from registers only.
   assign tx_ready = (state_reg == S_GRANT);
   assign stopped  = (state_reg != S_WAIT_ELEM);
   assign busy     = (state_reg != S_IDLE);
   assign tx_valid = tx_valid_reg;
   assign tx_byte  = tx_byte_reg;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (data_available) begin
               state_next = S_HDR;
            end
         end
         S_HDR: begin
            if (byte_done && (byte_idx_reg == 3'd2)) begin
               state_next = S_GRANT;
            end
         end
         S_GRANT: begin
            state_next = (elem_total != 16'd0) ? S_WAIT_ELEM : S_CHK;
         end
         S_WAIT_ELEM: begin
            if (elem_valid) begin
               state_next = S_ELEM;
            end
         end
         S_ELEM: begin
            if (byte_done && last_elem_byte) begin
               state_next = last_elem ? S_CHK : S_WAIT_ELEM;
            end
         end
         S_CHK: begin
            if (byte_done) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dim_x_reg    <= 8'd0;
         dim_y_reg    <= 8'd0;
         chk_reg      <= 8'd0;
         tx_byte_reg  <= 8'd0;
         tx_valid_reg <= 1'b0;
         byte_idx_reg <= 3'd0;
         elem_cnt_reg <= 16'd0;
         shift_reg    <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (data_available) begin
                  dim_x_reg    <= dim_x;
                  dim_y_reg    <= dim_y;
                  chk_reg      <= 8'd0;
                  byte_idx_reg <= 3'd0;
                  elem_cnt_reg <= 16'd0;
                  tx_valid_reg <= 1'b1;
                  tx_byte_reg  <= SYNC_BYTE;
               end
            end
            S_HDR: begin
               if (byte_done) begin
                  // The sync byte (index 0) is excluded from the checksum.
                  if (byte_idx_reg != 3'd0) begin
                     chk_reg <= chk_reg ^ tx_byte_reg;
                  end
                  case (byte_idx_reg)
                     3'd0: begin
                        tx_byte_reg  <= dim_x_reg;
                        byte_idx_reg <= 3'd1;
                     end
                     3'd1: begin
                        tx_byte_reg  <= dim_y_reg;
                        byte_idx_reg <= 3'd2;
                     end
                     default: begin
                        tx_valid_reg <= 1'b0;
                        byte_idx_reg <= 3'd0;
                     end
                  endcase
               end
            end
            S_GRANT: begin
               // Empty matrix: go straight to the checksum byte.
               if (elem_total == 16'd0) begin
                  tx_valid_reg <= 1'b1;
                  tx_byte_reg  <= chk_reg;
               end
            end
            S_WAIT_ELEM: begin
               if (elem_valid) begin
                  // First byte goes out directly; the rest queue up in the
                  // shift register, MSB-aligned.
                  tx_byte_reg  <= elem_data[DATA_WIDTH-1 -: 8];
                  shift_reg    <= elem_data << 8;
                  tx_valid_reg <= 1'b1;
                  byte_idx_reg <= 3'd0;
               end
            end
            S_ELEM: begin
               if (byte_done) begin
                  chk_reg <= chk_reg ^ tx_byte_reg;
                  if (last_elem_byte) begin
                     elem_cnt_reg <= elem_cnt_reg + 16'd1;
                     byte_idx_reg <= 3'd0;
                     if (last_elem) begin
                        // Checksum must include the byte being acked now.
                        tx_byte_reg <= chk_reg ^ tx_byte_reg;
                     end else begin
                        tx_valid_reg <= 1'b0;
                     end
                  end else begin
                     tx_byte_reg  <= shift_reg[DATA_WIDTH-1 -: 8];
                     shift_reg    <= shift_reg << 8;
                     byte_idx_reg <= byte_idx_reg + 3'd1;
                  end
               end
            end
            S_CHK: begin
               if (byte_done) begin
                  tx_valid_reg <= 1'b0;
                  tx_byte_reg  <= 8'd0;
               end
            end
            default: begin
               tx_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_out_transmitter.sv
// -----------------------------------------------------------------------------
// tb_out_transmitter
//
// Directed bench for out_transmitter with DATA_WIDTH=16. Expected frame bytes
// are pushed to a scoreboard queue when a frame is started and popped whenever
// the DUT hands a byte over (tx_valid && tx_ack). All driving happens from the
// single main initial block through the per-cycle tick task.
// -----------------------------------------------------------------------------
module tb_out_transmitter;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          data_available = 1'b0;
   logic [7:0]    dim_x = 8'd0;
   logic [7:0]    dim_y = 8'd0;
   logic          tx_ready;
   logic          stopped;
   logic          elem_valid = 1'b0;
   logic [DW-1:0] elem_data = '0;
   logic          tx_valid;
   logic [7:0]    tx_byte;
   logic          tx_ack = 1'b0;
   logic          busy;

   out_transmitter #(.DATA_WIDTH(DW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_available (data_available),
      .dim_x          (dim_x),
      .dim_y          (dim_y),
      .tx_ready       (tx_ready),
      .stopped        (stopped),
      .elem_valid     (elem_valid),
      .elem_data      (elem_data),
      .tx_valid       (tx_valid),
      .tx_byte        (tx_byte),
      .tx_ack         (tx_ack),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            da_cyc = 0;
   bit            pend_da = 1'b0;
   int            ack_mode = 0;     // 0: ack every cycle, 1: ack every 3rd cycle
   int            elem_mode = 0;    // 0: buffer queue, 1: free-running data
   logic [DW-1:0] buf_q[$];
   logic [7:0]    exp_q[$];
   int            tx_ready_cnt = 0;
   int            tx_ready_cyc = 0;
   int            stopped_lo_cnt = 0;
   int            accepted_cnt = 0;
   bit            prev_pending = 1'b0;
   logic [7:0]    prev_byte = 8'd0;
   logic          last_busy = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] fdat(input int c);
      logic [7:0] lo;
      lo = 8'(c);
      return {lo, lo ^ 8'h5A};
   endfunction

   // One clock cycle: observe at the falling edge, drive 1 ns after the rise.
   task automatic tick();
      logic       acc;
      logic [7:0] e;
      @(negedge clk);
      if (prev_pending) begin
         check("hold_valid", 64'(tx_valid), 64'd1);
         check("hold_byte", 64'(tx_byte), 64'(prev_byte));
      end
      if (tx_valid && tx_ack) begin
         if (exp_q.size() == 0) begin
            check("unexpected_byte_queue", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            $display("byte %02h (expected %02h) at cycle %0d", tx_byte, e, cyc);
            check("tx_byte", 64'(tx_byte), 64'(e));
         end
      end
      prev_pending = tx_valid && !tx_ack;
      prev_byte    = tx_byte;
      if (tx_ready) begin
         tx_ready_cnt++;
         tx_ready_cyc = cyc;
      end
      if (!stopped) stopped_lo_cnt++;
      acc = elem_valid && !stopped;
      if (acc) accepted_cnt++;
      last_busy = busy;
      @(posedge clk);
      #1;
      cyc++;
      if (acc && elem_mode == 0 && buf_q.size() != 0) void'(buf_q.pop_front());
      if (elem_mode == 0) begin
         elem_valid = (buf_q.size() != 0);
         elem_data  = elem_valid ? buf_q[0] : '0;
      end else begin
         elem_valid = 1'b1;
         elem_data  = fdat(cyc);
      end
      tx_ack         = (ack_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      data_available = pend_da;
      pend_da        = 1'b0;
   endtask

   task automatic expect_frame(input logic [7:0] dx, input logic [7:0] dy, input int n,
                               input logic [DW-1:0] e0, input logic [DW-1:0] e1);
      logic [7:0]    c;
      logic [DW-1:0] e;
      c = dx ^ dy;
      exp_q.push_back(8'hA5);
      exp_q.push_back(dx);
      exp_q.push_back(dy);
      for (int i = 0; i < n; i++) begin
         e = (i == 0) ? e0 : e1;
         exp_q.push_back(e[15:8]);
         exp_q.push_back(e[7:0]);
         c = c ^ e[15:8] ^ e[7:0];
      end
      exp_q.push_back(c);
   endtask

   task automatic start_frame(input logic [7:0] dx, input logic [7:0] dy);
      dim_x          = dx;
      dim_y          = dy;
      tx_ready_cnt   = 0;
      stopped_lo_cnt = 0;
      accepted_cnt   = 0;
      pend_da        = 1'b1;
      tick();
      da_cyc = cyc;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!last_busy && cyc > da_cyc + 2) break;
      end
      check({tag, "_idle"}, 64'(last_busy), 64'd0);
      check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      // ---- reset state
      repeat (3) tick();
      check("rst_tx_ready", 64'(tx_ready), 64'd0);
      check("rst_stopped", 64'(stopped), 64'd1);
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_tx_byte", 64'(tx_byte), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();

      // ---- 2x1 frame, continuous ack
      buf_q.push_back(16'h1234);
      buf_q.push_back(16'h5678);
      start_frame(8'd2, 8'd1);
      expect_frame(8'd2, 8'd1, 2, 16'h1234, 16'h5678);
      tick();
      check("first_byte_latency", 64'({tx_valid, tx_byte}), 64'({1'b1, 8'hA5}));
      wait_idle("f1");
      check("f1_tx_ready_cnt", 64'(tx_ready_cnt), 64'd1);
      check("f1_tx_ready_cyc", 64'(tx_ready_cyc), 64'(da_cyc + 4));
      check("f1_stopped_lo", 64'(stopped_lo_cnt), 64'd2);
      check("f1_accepted", 64'(accepted_cnt), 64'd2);

      // ---- same frame, ack only every third cycle
      ack_mode = 1;
      buf_q.push_back(16'h1234);
      buf_q.push_back(16'h5678);
      start_frame(8'd2, 8'd1);
      expect_frame(8'd2, 8'd1, 2, 16'h1234, 16'h5678);
      wait_idle("f2");
      check("f2_tx_ready_cnt", 64'(tx_ready_cnt), 64'd1);
      check("f2_stopped_lo", 64'(stopped_lo_cnt), 64'd2);
      check("f2_accepted", 64'(accepted_cnt), 64'd2);
      ack_mode = 0;
      tick();

      // ---- empty matrix 0x5
      start_frame(8'd0, 8'd5);
      expect_frame(8'd0, 8'd5, 0, '0, '0);
      wait_idle("f3");
      check("f3_tx_ready_cnt", 64'(tx_ready_cnt), 64'd1);
      check("f3_stopped_lo", 64'(stopped_lo_cnt), 64'd0);

      // ---- element data changing every cycle: only WAIT_ELEM values count
      elem_mode = 1;
      start_frame(8'd2, 8'd1);
      expect_frame(8'd2, 8'd1, 2, fdat(da_cyc + 5), fdat(da_cyc + 8));
      wait_idle("f4");
      check("f4_accepted", 64'(accepted_cnt), 64'd2);
      elem_mode = 0;
      tick();

      // ---- reset while the second element byte is on the bus
      buf_q.push_back(16'h1234);
      buf_q.push_back(16'h5678);
      start_frame(8'd2, 8'd1);
      expect_frame(8'd2, 8'd1, 2, 16'h1234, 16'h5678);
      repeat (7) tick();
      check("f5_second_elem_byte", 64'(tx_byte), 64'h34);
      rst_n = 1'b0;
      tick();
      check("f5_rst_tx_ready", 64'(tx_ready), 64'd0);
      check("f5_rst_stopped", 64'(stopped), 64'd1);
      check("f5_rst_tx_valid", 64'(tx_valid), 64'd0);
      check("f5_rst_tx_byte", 64'(tx_byte), 64'd0);
      check("f5_rst_busy", 64'(busy), 64'd0);
      exp_q.delete();
      buf_q.delete();
      prev_pending = 1'b0;
      rst_n = 1'b1;
      tick();
      buf_q.push_back(16'hABCD);
      start_frame(8'd1, 8'd1);
      expect_frame(8'd1, 8'd1, 1, 16'hABCD, '0);
      wait_idle("f5b");
      check("f5b_tx_ready_cnt", 64'(tx_ready_cnt), 64'd1);

      // ---- data_available pulse during ELEM is ignored
      buf_q.push_back(16'h1234);
      buf_q.push_back(16'h5678);
      start_frame(8'd2, 8'd1);
      expect_frame(8'd2, 8'd1, 2, 16'h1234, 16'h5678);
      repeat (6) tick();
      pend_da = 1'b1;
      wait_idle("f6");
      check("f6_tx_ready_cnt", 64'(tx_ready_cnt), 64'd1);
      repeat (6) tick();
      check("f6_no_second_header", 64'(tx_valid), 64'd0);
      check("f6_still_idle", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
